mips_multi_ctrl_ws: RTL
=======================

# mips_multi_ctrl_ws

Second-generation multicycle MIPS controller: drop-in replacement for the fixed-latency controller, driving the same multicycle datapath (PC, IR, A/B, ALUOut, data registers). It adds a memory request/ready handshake with wait states and a bounded timeout. It also adds an extended immediate/jump instruction set, a sticky fault state for illegal encodings, and cycle/retired-instruction counters.

## Interface
Parameters:
- MEM_TIMEOUT, 16, wait cycles tolerated per memory access before fault; 0 disables the timeout
- TO_W, 5, timeout counter width; must satisfy 2^TO_W > MEM_TIMEOUT
- CNT_W, 32, width of the performance counters

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- op  in  6  instr[31:26]
- funct  in  6  instr[5:0]
- zero  in  1  ALU zero flag
- memready  in  1  memory completes the current access this cycle
- memreq  out  1  memory access in progress
- memwrite  out  1  write strobe; only asserted together with memreq
- iord  out  1  address select: 0 = PC, 1 = ALUOut
- irwrite  out  1  IR load enable
- pcen  out  1  PC load enable
- regwrite  out  1  register file write enable
- regdst  out  2  write register select: 00 = rt, 01 = rd, 10 = $31
- memtoreg  out  2  write data select: 00 = ALUOut, 01 = data register, 10 = PC
- alusrca  out  1  ALU A select: 0 = PC, 1 = A
- alusrcb  out  2  ALU B select: 00 = B, 01 = 4, 10 = extended immediate, 11 = sign-extended immediate << 2
- immext  out  1  immediate extension: 1 = zero-extend, 0 = sign-extend
- pcsrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alucontrol  out  3  ALU operation code
- fault  out  1  controller halted in FAULT
- cycles  out  CNT_W  cycle counter
- instret  out  CNT_W  retired-instruction counter

## Operation
- Opcodes: lw 100011, sw 101011, R 000000, beq 000100, bne 000101, addi 001000, slti 001010, andi 001100, ori 001101, xori 001110, j 000010, jal 000011.
- R-type funct codes: add 100000, sub 100010, and 100100, or 100101, slt 101010.
- ALU codes: add 010, sub 110, and 000, or 001, xor 011, slt 111.
- Unlisted outputs in any state are 0. Where regdst/memtoreg are unused, they are 00.

FSM states and behaviour:
- FETCH:
  - memreq=1, iord=0, alusrca=0, alusrcb=01, alucontrol=add, pcsrc=00.
  - irwrite=pcen=memready.
  - Stays in FETCH while memready=0; goes to DECODE when memready=1.
- DECODE:
  - alusrca=0, alusrcb=11, alucontrol=add (branch target into ALUOut).
  - lw/sw -> MEMADR; R -> RTYPEEX; beq -> BEQEX; bne -> BNEEX; addi/slti/andi/ori/xori -> IMMEX; j -> JEX; jal -> JALEX.
  - Any other opcode, or R-type with an unlisted funct, -> FAULT.
- MEMADR: alusrca=1, alusrcb=10, immext=0, add. lw -> MEMRD; sw -> MEMWR.
- MEMRD: memreq=1, iord=1. Stays while memready=0; -> MEMWB when memready=1.
- MEMWB: regwrite=1, regdst=00, memtoreg=01. -> FETCH.
- MEMWR: memreq=1, memwrite=1, iord=1 for the whole state. -> FETCH when memready=1.
- RTYPEEX: alusrca=1, alusrcb=00, alucontrol from funct. -> RTYPEWB.
- RTYPEWB: regwrite=1, regdst=01, memtoreg=00. -> FETCH.
- BEQEX: alusrca=1, alusrcb=00, sub, pcsrc=01, pcen=zero. -> FETCH.
- BNEEX: as BEQEX, but pcen=~zero. -> FETCH.
- IMMEX:
  - alusrca=1, alusrcb=10.
  - addi: add, immext=0. slti: slt, immext=0. andi: and, immext=1. ori: or, immext=1. xori: xor, immext=1.
  - -> IMMWB.
- IMMWB: regwrite=1, regdst=00, memtoreg=00. alucontrol and immext are held from IMMEX. -> FETCH.
- JEX: pcsrc=10, pcen=1. -> FETCH.
- JALEX:
  - pcsrc=10, pcen=1, regwrite=1, regdst=10, memtoreg=10.
  - $31 receives the pre-edge PC, which is already PC+4.
  - -> FETCH.
- FAULT: every enable is 0 and fault=1. Stays in FAULT until reset.

Timeout:
- TO_W counter clears on entry to FETCH, MEMRD or MEMWR, and whenever memready=1.
- It increments each cycle spent in one of those states with memready=0.
- When it equals MEM_TIMEOUT with memready still 0 (MEM_TIMEOUT≠0), the next state is FAULT. memready=1 in that same cycle wins, and the access completes.

Counters:
- cycles increments every cycle not in FAULT.
- instret increments on each cycle whose next state is FETCH and whose current state is not FETCH.
- Both counters wrap modulo 2^CNT_W and are frozen in FAULT.

## Timing
- Reset: state = FETCH, timeout counter = 0, cycles = instret = 0.
  - Outputs during reset: memreq=1, iord=0, alusrcb=01, alucontrol=010, fault=0. pcen and irwrite follow memready.
  - Deasserting reset mid-access restarts the current instruction from FETCH at the current PC.
- Moore outputs: everything decoded from the state register and op/funct, except pcen and irwrite.
- Mealy outputs: pcen and irwrite are combinational from memready/zero in the same cycle.
- fault is registered: it goes high in the cycle after the transition edge.
- Latency with memready always 1: lw 5, sw 4, R-type 4, immediate 4, beq/bne 3, j 3, jal 3 cycles.
- Each wait cycle on FETCH, MEMRD or MEMWR adds exactly 1 cycle.
- memwrite never asserts outside MEMWR, and is always accompanied by memreq=1.

## Test plan
- Reset, memready=1, lw then addi: state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB, then FETCH, DECODE, IMMEX, IMMWB. instret=2 and cycles=9 after the 9th edge.
- sw with memready low for 3 cycles in MEMWR: memwrite=memreq=1 for 4 cycles, iord=1, then FETCH. Latency is 7.
- bne with zero=0: pcen=1, pcsrc=01 in BNEEX. Same instruction with zero=1: pcen=0. beq gives the inverse.
- andi: immext=1, alucontrol=000 in IMMEX and IMMWB. jal: JALEX shows regdst=10, memtoreg=10, regwrite=1, pcen=1, pcsrc=10.
- MEM_TIMEOUT=4, memready held 0 in FETCH: fault=1 after cycle 6. All enables are 0 thereafter, and counters are frozen until reset.
- op=111111: DECODE -> FAULT. R-type funct=000000 -> FAULT. A reset pulse returns to FETCH with counters at 0.

Source files
------------

// File: rtl/mips_multi_ctrl_ws_if.sv
// Control bus between the multicycle MIPS controller (master) and its datapath/memory (slave).
interface mips_multi_ctrl_ws_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memready;
    logic       memreq;
    logic       memwrite;
    logic       iord;
    logic       irwrite;
    logic       pcen;
    logic       regwrite;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       immext;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;

    modport master (
        input  op, funct, zero, memready,
        output memreq, memwrite, iord, irwrite, pcen, regwrite, regdst, memtoreg,
               alusrca, alusrcb, immext, pcsrc, alucontrol
    );

    modport slave (
        output op, funct, zero, memready,
        input  memreq, memwrite, iord, irwrite, pcen, regwrite, regdst, memtoreg,
               alusrca, alusrcb, immext, pcsrc, alucontrol
    );
endinterface

// File: rtl/mips_multi_ctrl_ws.sv
// Multicycle MIPS controller with memory wait states, access timeout, sticky fault
// and cycle/retired-instruction counters.
module mips_multi_ctrl_ws #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    mips_multi_ctrl_ws_if.master bus,
    output logic                 fault,
    output logic [CNT_W-1:0]     cycles,
    output logic [CNT_W-1:0]     instret
);
    localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000,
                           OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000,
                           OP_SLTI = 6'b001010, OP_ANDI = 6'b001100, OP_ORI = 6'b001101,
                           OP_XORI = 6'b001110, OP_J = 6'b000010, OP_JAL = 6'b000011;
    localparam logic [2:0] ALU_ADD = 3'b010, ALU_SUB = 3'b110, ALU_AND = 3'b000,
                           ALU_OR = 3'b001, ALU_XOR = 3'b011, ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB,
        BEQEX, BNEEX, IMMEX, IMMWB, JEX, JALEX, FAULT
    } state_t;

    state_t          state, nxt;
    logic [TO_W-1:0] to_cnt;
    logic            waiting;
    logic            funct_ok;
    logic [2:0]      r_alu;
    logic [2:0]      i_alu;
    logic            i_zext;

    always_comb begin
        funct_ok = 1'b1;
        r_alu    = ALU_ADD;
        unique case (bus.funct)
            6'b100000: r_alu = ALU_ADD;
            6'b100010: r_alu = ALU_SUB;
            6'b100100: r_alu = ALU_AND;
            6'b100101: r_alu = ALU_OR;
            6'b101010: r_alu = ALU_SLT;
            default:   funct_ok = 1'b0;
        endcase
        // Logical immediates zero-extend; arithmetic ones sign-extend.
        i_alu  = ALU_ADD;
        i_zext = 1'b0;
        unique case (bus.op)
            OP_SLTI: i_alu = ALU_SLT;
            OP_ANDI: begin i_alu = ALU_AND; i_zext = 1'b1; end
            OP_ORI:  begin i_alu = ALU_OR;  i_zext = 1'b1; end
            OP_XORI: begin i_alu = ALU_XOR; i_zext = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= nxt;
    end

    always_comb begin
        nxt            = state;
        bus.memreq     = 1'b0;
        bus.memwrite   = 1'b0;
        bus.iord       = 1'b0;
        bus.irwrite    = 1'b0;
        bus.pcen       = 1'b0;
        bus.regwrite   = 1'b0;
        bus.regdst     = 2'b00;
        bus.memtoreg   = 2'b00;
        bus.alusrca    = 1'b0;
        bus.alusrcb    = 2'b00;
        bus.immext     = 1'b0;
        bus.pcsrc      = 2'b00;
        bus.alucontrol = 3'b000;
        unique case (state)
            FETCH: begin
                bus.memreq     = 1'b1;
                bus.alusrcb    = 2'b01;
                bus.alucontrol = ALU_ADD;
                bus.irwrite    = bus.memready;
                bus.pcen       = bus.memready;
                if (bus.memready) nxt = DECODE;
            end
            DECODE: begin
                bus.alusrcb    = 2'b11;
                bus.alucontrol = ALU_ADD;
                unique case (bus.op)
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_R:         nxt = funct_ok ? RTYPEEX : FAULT;
                    OP_BEQ:       nxt = BEQEX;
                    OP_BNE:       nxt = BNEEX;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: nxt = IMMEX;
                    OP_J:         nxt = JEX;
                    OP_JAL:       nxt = JALEX;
                    default:      nxt = FAULT;
                endcase
            end
            MEMADR: begin
                bus.alusrca    = 1'b1;
                bus.alusrcb    = 2'b10;
                bus.alucontrol = ALU_ADD;
                nxt            = (bus.op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                bus.memreq = 1'b1;
                bus.iord   = 1'b1;
                if (bus.memready) nxt = MEMWB;
            end
            MEMWB: begin
                bus.regwrite = 1'b1;
                bus.memtoreg = 2'b01;
                nxt          = FETCH;
            end
            MEMWR: begin
                bus.memreq   = 1'b1;
                bus.memwrite = 1'b1;
                bus.iord     = 1'b1;
                if (bus.memready) nxt = FETCH;
            end
            RTYPEEX: begin
                bus.alusrca    = 1'b1;
                bus.alucontrol = r_alu;
                nxt            = RTYPEWB;
            end
            RTYPEWB: begin
                bus.regwrite = 1'b1;
                bus.regdst   = 2'b01;
                nxt          = FETCH;
            end
            BEQEX, BNEEX: begin
                bus.alusrca    = 1'b1;
                bus.alucontrol = ALU_SUB;
                bus.pcsrc      = 2'b01;
                bus.pcen       = (state == BEQEX) ? bus.zero : ~bus.zero;
                nxt            = FETCH;
            end
            IMMEX: begin
                bus.alusrca    = 1'b1;
                bus.alusrcb    = 2'b10;
                bus.alucontrol = i_alu;
                bus.immext     = i_zext;
                nxt            = IMMWB;
            end
            IMMWB: begin
                bus.regwrite   = 1'b1;
                bus.alucontrol = i_alu;
                bus.immext     = i_zext;
                nxt            = FETCH;
            end
            JEX: begin
                bus.pcsrc = 2'b10;
                bus.pcen  = 1'b1;
                nxt       = FETCH;
            end
            JALEX: begin
                bus.pcsrc    = 2'b10;
                bus.pcen     = 1'b1;
                bus.regwrite = 1'b1;
                bus.regdst   = 2'b10;
                bus.memtoreg = 2'b10;
                nxt          = FETCH;
            end
            FAULT:   nxt = FAULT;
            default: nxt = FAULT;
        endcase
        // A completing access (memready=1) always beats the timeout.
        if (waiting && MEM_TIMEOUT != 0 && to_cnt == TO_W'(MEM_TIMEOUT)) nxt = FAULT;
    end

    assign waiting = (state == FETCH || state == MEMRD || state == MEMWR) && !bus.memready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                        to_cnt <= '0;
        else if (waiting && nxt == state) to_cnt <= to_cnt + 1'b1;
        else                              to_cnt <= '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycles  <= '0;
            instret <= '0;
        end else if (state != FAULT) begin
            cycles <= cycles + 1'b1;
            if (nxt == FETCH && state != FETCH) instret <= instret + 1'b1;
        end
    end

    assign fault = (state == FAULT);
endmodule
